instruct_pack: RTL
==================

Name: instruct_pack

Overview:
- Instruction packer: the inverse of the field splitter. Takes decoded MIPS fields plus a format selector and assembles the 32-bit instruction word.
- Buffers assembled words in a 2-entry FIFO and presents them with a sequential instruction-memory address on a valid/ready output.
- Used by the program loader and self-test path to write generated code into instruction memory.

Parameters:
- ADDR_W, 10, width of the word address and of the address counter.
- BASE_ADDR, 0, word address loaded on reset and on start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: flush FIFO, reload address, clear status.
- in_valid  in  1  input fields valid.
- in_ready  out  1  packer can accept the input fields.
- fmt  in  2  field format: 00 R, 01 I, 10 J, 11 illegal.
- op  in  6  opcode, placed in bits [31:26].
- rs  in  5  placed in bits [25:21] (R, I).
- rt  in  5  placed in bits [20:16] (R, I).
- rd  in  5  placed in bits [15:11] (R).
- shamt  in  5  placed in bits [10:6] (R).
- funct  in  6  placed in bits [5:0] (R).
- imm16  in  16  placed in bits [15:0] (I).
- target26  in  26  placed in bits [25:0] (J).
- out_valid  out  1  out_inst and out_addr valid.
- out_ready  in  1  memory writer accepts the word.
- out_inst  out  32  assembled instruction.
- out_addr  out  ADDR_W  word address for out_inst.
- word_count  out  ADDR_W+1  words delivered since the last start; saturating.
- err_illegal  out  1  sticky: an fmt=11 input was accepted.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO empty, out_valid=0, out_inst=0.
  - Address counter and out_addr = BASE_ADDR.
  - word_count=0, err_illegal=0.
  - in_ready is 0 while rst_n=0.
- Packing rules (combinational on the inputs, captured on accept):
  - R: {op,rs,rt,rd,shamt,funct}.
  - I: {op,rs,rt,imm16}.
  - J: {op,target26}.
  - Fields not used by the selected format are ignored.
- Input accept: in_valid & in_ready at a rising edge.
  - in_ready = (FIFO count < 2) & ~start.
  - in_ready has no combinational path from out_ready.
- Illegal format: an accepted fmt=11 is not enqueued and sets err_illegal. err_illegal stays set until start or reset.
- Latency: an accepted word appears at out_valid on the next cycle if the FIFO was empty. Otherwise it appears in FIFO order behind the earlier words.
- Throughput: 1 word/cycle when out_ready is held high.
- Output: out_valid = FIFO non-empty. out_inst is the FIFO head. out_inst and out_addr hold stable while out_valid & ~out_ready.
- Output handshake: out_valid & out_ready pops the head and increments the address counter by 1.
  - The address wraps from 2^ADDR_W-1 to 0; no flag is raised.
  - word_count increments and saturates at 2^(ADDR_W+1)-1.
- Simultaneous push and pop:
  - Count 1: count stays 1 and the new word becomes the head next cycle.
  - Count 2: push is impossible because in_ready=0.
- start (synchronous, highest priority):
  - Next cycle: FIFO empty, address = BASE_ADDR, word_count=0, err_illegal=0.
  - An input presented in the start cycle is not accepted, since in_ready=0.
  - An output handshake in the start cycle is discarded: no count or address update.
- Reset asserted mid-transfer: all state clears immediately. Buffered words are lost.

Test Plan:
- R word: after reset, fmt=00, op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20, out_ready=1 -> next cycle out_valid=1, out_inst=0x00221820, out_addr=0; following cycle word_count=1.
- I and J back-to-back:
  - I word: fmt=01, op=0x08, rs=0, rt=8, imm16=0x0005.
  - J word: fmt=10, op=0x02, target26=0x0100000.
  - Required: outputs 0x20080005 at addr 0, then 0x08100000 at addr 1, on consecutive cycles.
- Backpressure: out_ready=0 while 3 valid words are offered -> first 2 accepted, then in_ready=0 and out_inst held stable. Raise out_ready -> words emerge in order at addr 0,1,2 with no loss or duplication.
- Illegal: fmt=11 accepted -> no out_valid, err_illegal=1. A subsequent legal word still goes to addr 0. start -> err_illegal=0.
- Wrap and start, ADDR_W=2: deliver 5 words -> addresses 0,1,2,3,0 and word_count=5. Pulse start while the FIFO holds 1 word -> FIFO flushed, next word goes to addr 0, word_count=0.
- Async reset mid-stream: drop rst_n between clock edges with 2 words buffered -> out_valid=0 and out_addr=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruct_pack.sv
// Instruction packer: assembles R/I/J MIPS words from decoded fields,
// buffers them in a 2-entry FIFO and emits them with sequential word
// addresses on a valid/ready interface.
module instruct_pack #(
  parameter int unsigned          ADDR_W    = 10,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target26,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal
);

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_BAD = 2'b11
  } fmt_e;

  fmt_e              fmt_sel;
  logic [31:0]       packed_word;
  logic              accept, push, pop;

  // FIFO is held as an explicit head/tail pair so the head drives out_inst directly
  logic [31:0]       head_q, head_d;
  logic [31:0]       tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              err_q, err_d;

  assign fmt_sel = fmt_e'(fmt);

  // Field assembly for the selected format; unused fields are ignored
  always_comb begin
    packed_word = '0;
    case (fmt_sel)
      FMT_R:   packed_word = {op, rs, rt, rd, shamt, funct};
      FMT_I:   packed_word = {op, rs, rt, imm16};
      FMT_J:   packed_word = {op, target26};
      default: packed_word = '0;
    endcase
  end

  // in_ready depends only on local state, start and reset, never on out_ready
  assign in_ready  = rst_n & (count_q != 2'd2) & ~start;
  assign accept    = in_valid & in_ready;
  assign push      = accept & (fmt_sel != FMT_BAD);
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready & ~start;

  // Next-state for FIFO, address counter, delivered-word count and error flag
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    if (start) begin
      count_d = 2'd0;
      addr_d  = BASE_ADDR;
      wcnt_d  = '0;
      err_d   = 1'b0;
    end else begin
      if (accept && fmt_sel == FMT_BAD) err_d = 1'b1;
      // push+pop only happens with one entry held: the new word replaces the head
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = packed_word;
          else                 tail_d = packed_word;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: head_d = packed_word;
        default: ;
      endcase
      if (pop) begin
        addr_d = addr_q + 1'b1;
        if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      addr_q  <= BASE_ADDR;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign out_inst    = head_q;
  assign out_addr    = addr_q;
  assign word_count  = wcnt_q;
  assign err_illegal = err_q;

endmodule
